// File: rtl/pm_ctrl_pkg.sv
// Shared types and helpers for the toggle-handshake power-switch sequencer.
package pm_ctrl_pkg;

   typedef enum logic [2:0] {
      PM_OFF    = 3'd0,
      PM_PWR_UP = 3'd1,
      PM_ON     = 3'd2,
      PM_PWR_DN = 3'd3,
      PM_ERR    = 3'd4
   } pm_ch_state_e;

   localparam int unsigned PM_SYNC_MIN = 2;

   // Counter must hold 0..TIMEOUT_CYC; keep at least one bit when timeout is disabled.
   function automatic int unsigned pm_cnt_width(input int unsigned timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/pm_ctrl_toggle_hs_ch.sv
// One power-switch channel: ack synchroniser, XOR completion compare,
// sequencing FSM and saturating transition timeout counter.
module pm_ctrl_toggle_hs_ch
   import pm_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic on_req_i,
   input  logic clr_err_i,
   input  logic ack_i,
   output logic req_o,
   output logic pwr_on_o,
   output logic busy_o,
   output logic done_o,
   output logic err_o
);

   localparam int unsigned SYNC_N = (SYNC_STAGES < PM_SYNC_MIN) ? PM_SYNC_MIN : SYNC_STAGES;
   localparam int unsigned CNT_W  = pm_cnt_width(TIMEOUT_CYC);
   localparam bit          TO_EN  = (TIMEOUT_CYC != 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC != 0) ? TIMEOUT_CYC - 1 : 0);

   pm_ch_state_e       state_q, state_d;
   logic               req_q,   req_d;
   logic               done_q,  done_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [SYNC_N-1:0]  sync_q,  sync_d;
   logic               ack_s;
   logic               pend;

   assign ack_s = sync_q[SYNC_N-1];
   assign pend  = req_q ^ ack_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PM_OFF;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         sync_q  <= sync_d;
      end
   end

   // Next state; a transition in flight cannot be aborted, completion beats timeout.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      sync_d  = {sync_q[SYNC_N-2:0], ack_i};
      unique case (state_q)
         PM_OFF: begin
            if (en_i && on_req_i) begin
               req_d   = ~req_q;
               cnt_d   = '0;
               state_d = PM_PWR_UP;
            end else if (pend) begin
               state_d = PM_ERR;
            end
         end
         PM_ON: begin
            if (en_i && !on_req_i) begin
               req_d   = ~req_q;
               cnt_d   = '0;
               state_d = PM_PWR_DN;
            end else if (pend) begin
               state_d = PM_ERR;
            end
         end
         PM_PWR_UP, PM_PWR_DN: begin
            if (!pend) begin
               state_d = (state_q == PM_PWR_UP) ? PM_ON : PM_OFF;
               done_d  = 1'b1;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               state_d = PM_ERR;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PM_ERR: begin
            if (clr_err_i) begin
               req_d   = ack_s;
               cnt_d   = '0;
               state_d = PM_OFF;
            end
         end
         default: state_d = PM_OFF;
      endcase
   end

   assign req_o    = req_q;
   assign done_o   = done_q;
   assign pwr_on_o = (state_q == PM_ON);
   assign busy_o   = (state_q == PM_PWR_UP) || (state_q == PM_PWR_DN);
   assign err_o    = (state_q == PM_ERR);

endmodule

// File: rtl/pm_ctrl_toggle_hs.sv
// N-channel power-switch sequencer: independent toggle-handshake channels
// with a shared interrupt on completion or error.
module pm_ctrl_toggle_hs
   import pm_ctrl_pkg::*;
#(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned SYNC_STAGES = PM_SYNC_MIN,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N_CH-1:0] en_i,
   input  logic [N_CH-1:0] on_req_i,
   input  logic [N_CH-1:0] clr_err_i,
   input  logic [N_CH-1:0] ack_i,
   output logic [N_CH-1:0] req_o,
   output logic [N_CH-1:0] pwr_on_o,
   output logic [N_CH-1:0] busy_o,
   output logic [N_CH-1:0] done_o,
   output logic [N_CH-1:0] err_o,
   output logic            irq_o
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pm_ctrl_toggle_hs_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_ch (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .en_i      (en_i[i]),
         .on_req_i  (on_req_i[i]),
         .clr_err_i (clr_err_i[i]),
         .ack_i     (ack_i[i]),
         .req_o     (req_o[i]),
         .pwr_on_o  (pwr_on_o[i]),
         .busy_o    (busy_o[i]),
         .done_o    (done_o[i]),
         .err_o     (err_o[i])
      );
   end

   assign irq_o = |(done_o | err_o);

endmodule

// File: tb/tb_pm_ctrl_toggle_hs.sv
// Directed self-checking bench for pm_ctrl_toggle_hs (4 channels, 2 sync stages, timeout 8).
module tb_pm_ctrl_toggle_hs;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] en, on_req, clr_err, ack;
   logic [3:0] req_o, pwr_on_o, busy_o, done_o, err_o;
   logic       irq_o;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   pm_ctrl_toggle_hs #(
      .N_CH        (4),
      .SYNC_STAGES (2),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (en),
      .on_req_i  (on_req),
      .clr_err_i (clr_err),
      .ack_i     (ack),
      .req_o     (req_o),
      .pwr_on_o  (pwr_on_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .irq_o     (irq_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = '0; on_req = '0; clr_err = '0; ack = '0;
      tick(2);
      chk("rst_req",    32'(req_o),    32'h0);
      chk("rst_pwr_on", 32'(pwr_on_o), 32'h0);
      chk("rst_busy",   32'(busy_o),   32'h0);
      chk("rst_done",   32'(done_o),   32'h0);
      chk("rst_err",    32'(err_o),    32'h0);
      chk("rst_irq",    32'(irq_o),    32'h0);
      rst_n = 1'b1;
      tick(1);
      en = 4'hF;

      // Reset asserted in the middle of a ch0 power-up
      on_req[0] = 1'b1;
      tick(1);
      chk("t1_req0",  32'(req_o),  32'h1);
      chk("t1_busy0", 32'(busy_o), 32'h1);
      tick(2);
      rst_n = 1'b0;
      #1;
      chk("t1_async_req",  32'(req_o),  32'h0);
      chk("t1_async_busy", 32'(busy_o), 32'h0);
      chk("t1_async_irq",  32'(irq_o),  32'h0);
      on_req[0] = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("t1_post_req",  32'(req_o),  32'h0);
      chk("t1_post_busy", 32'(busy_o), 32'h0);

      // Power up ch0; ack returns 5 cycles after req (lands on the timeout limit cycle)
      on_req[0] = 1'b1;
      tick(1);
      chk("t2_req",  32'(req_o),  32'h1);
      chk("t2_busy", 32'(busy_o), 32'h1);
      tick(5);
      ack[0] = 1'b1;
      tick(2);
      chk("t2_done_early", 32'(done_o[0]), 32'h0);
      chk("t2_busy_early", 32'(busy_o[0]), 32'h1);
      tick(1);
      chk("t2_done",   32'(done_o),   32'h1);
      chk("t2_pwr_on", 32'(pwr_on_o), 32'h1);
      chk("t2_err",    32'(err_o),    32'h0);
      chk("t2_irq",    32'(irq_o),    32'h1);
      tick(1);
      chk("t2_done_pulse", 32'(done_o),      32'h0);
      chk("t2_on_hold",    32'(pwr_on_o[0]), 32'h1);
      chk("t2_irq_clr",    32'(irq_o),       32'h0);

      // Timeout: power down ch0 and never return the ack
      on_req[0] = 1'b0;
      tick(1);
      chk("t3_req_tog", 32'(req_o[0]),  32'h0);
      chk("t3_busy",    32'(busy_o[0]), 32'h1);
      tick(7);
      chk("t3_err_pre",  32'(err_o[0]),  32'h0);
      chk("t3_busy_pre", 32'(busy_o[0]), 32'h1);
      tick(1);
      chk("t3_err",      32'(err_o),     32'h1);
      chk("t3_busy_off", 32'(busy_o[0]), 32'h0);
      chk("t3_req_held", 32'(req_o[0]),  32'h0);
      chk("t3_irq",      32'(irq_o),     32'h1);
      clr_err[0] = 1'b1;
      tick(1);
      clr_err[0] = 1'b0;
      chk("t3_clr_err",    32'(err_o[0]),    32'h0);
      chk("t3_req_ack_s",  32'(req_o[0]),    32'h1);
      chk("t3_off_pwr_on", 32'(pwr_on_o[0]), 32'h0);
      tick(1);
      chk("t3_off_stable", 32'(err_o[0]), 32'h0);

      // Spurious ack on idle ch1; clr_err on a non-ERR channel is ignored
      ack[1] = 1'b1;
      tick(2);
      chk("t4_err_pre", 32'(err_o[1]), 32'h0);
      tick(1);
      chk("t4_err",      32'(err_o),    32'h2);
      chk("t4_irq",      32'(irq_o),    32'h1);
      chk("t4_req_iso",  32'(req_o),    32'h1);
      chk("t4_pwr_iso",  32'(pwr_on_o), 32'h0);
      clr_err = 4'h4;
      tick(1);
      chk("t4_clr_ign_err",  32'(err_o),  32'h2);
      chk("t4_clr_ign_busy", 32'(busy_o), 32'h0);
      clr_err = 4'h2;
      tick(1);
      clr_err = 4'h0;
      chk("t4_clr_err", 32'(err_o), 32'h0);
      chk("t4_req1",    32'(req_o), 32'h3);
      chk("t4_irq_clr", 32'(irq_o), 32'h0);

      // No abort: ch2 request withdrawn during power-up
      on_req[2] = 1'b1;
      tick(1);
      chk("t5_req_up", 32'(req_o[2]),  32'h1);
      chk("t5_busy",   32'(busy_o[2]), 32'h1);
      on_req[2] = 1'b0;
      tick(1);
      ack[2] = 1'b1;
      tick(2);
      chk("t5_still_busy", 32'(busy_o[2]), 32'h1);
      chk("t5_no_done",    32'(done_o),    32'h0);
      tick(1);
      chk("t5_done_up", 32'(done_o),      32'h4);
      chk("t5_on",      32'(pwr_on_o[2]), 32'h1);
      chk("t5_req_hi",  32'(req_o[2]),    32'h1);
      tick(1);
      chk("t5_req_dn",  32'(req_o[2]),    32'h0);
      chk("t5_busy_dn", 32'(busy_o[2]),   32'h1);
      chk("t5_not_on",  32'(pwr_on_o[2]), 32'h0);
      chk("t5_done_lo", 32'(done_o),      32'h0);
      ack[2] = 1'b0;
      tick(2);
      chk("t5_busy_dn2", 32'(busy_o[2]), 32'h1);
      tick(1);
      chk("t5_done_dn", 32'(done_o),      32'h4);
      chk("t5_off_pwr", 32'(pwr_on_o[2]), 32'h0);
      chk("t5_off_bsy", 32'(busy_o[2]),   32'h0);

      // Race: ch3 ack seen on the very cycle the counter reaches the limit
      on_req[3] = 1'b1;
      tick(1);
      chk("t6_req", 32'(req_o[3]), 32'h1);
      tick(5);
      ack[3] = 1'b1;
      tick(2);
      chk("t6_busy_pre", 32'(busy_o[3]), 32'h1);
      tick(1);
      chk("t6_on",   32'(pwr_on_o[3]), 32'h1);
      chk("t6_done", 32'(done_o),      32'h8);
      chk("t6_err",  32'(err_o),       32'h0);
      tick(1);
      chk("t6_err_after", 32'(err_o),       32'h0);
      chk("t6_on_after",  32'(pwr_on_o[3]), 32'h1);

      // One cycle too late: ch1 ack returns after the limit -> ERR
      on_req[1] = 1'b1;
      tick(1);
      chk("t7_req_tog", 32'(req_o[1]), 32'h0);
      tick(6);
      ack[1] = 1'b0;
      tick(2);
      chk("t7_err",   32'(err_o),       32'h2);
      chk("t7_no_on", 32'(pwr_on_o[1]), 32'h0);
      clr_err[1] = 1'b1;
      on_req[1] = 1'b0;
      tick(1);
      clr_err[1] = 1'b0;
      chk("t7_clr_err", 32'(err_o),    32'h0);
      chk("t7_req_sync", 32'(req_o[1]), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
